// File: rtl/fu_mem_agu_pkg.sv
// rtl/fu_mem_agu_pkg.sv - shared types, funct3 encodings and helpers for the memory AGU
package fu_mem_agu_pkg;

    // Access size as encoded in funct3[1:0]
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } mem_size_t;

    // RV load/store funct3 encodings (stores use the signed-form codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] size_bytes(input mem_size_t sz);
        logic [3:0] n;
        case (sz)
            SZ_BYTE: n = 4'd1;
            SZ_HALF: n = 4'd2;
            SZ_WORD: n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Doubleword and unsigned-word forms only exist on a 64-bit datapath
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store, input logic xlen64);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (xlen64 && (f3 == F3_D));
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU)
               || (xlen64 && ((f3 == F3_D) || (f3 == F3_WU)));
        end
        return ok;
    endfunction

endpackage

// File: rtl/fu_mem_agu_if.sv
// rtl/fu_mem_agu_if.sv - issue-side and LSQ-side handshake bundle of the memory AGU
interface fu_mem_agu_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) ();
    localparam int MASK_W = XLEN / 8;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   rs1_v;
    logic [XLEN-1:0]   rs2_v;
    logic [XLEN-1:0]   imm;
    logic [2:0]        funct3;
    logic              is_store;
    logic [IDX_W-1:0]  idx_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_addr;
    logic [MASK_W-1:0] out_mask;
    logic [XLEN-1:0]   out_wdata;
    logic [2:0]        out_funct3;
    logic              out_is_store;
    logic              out_misalign;
    logic              out_illegal;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  flush, in_valid, rs1_v, rs2_v, imm, funct3, is_store, idx_in, out_ready,
        output in_ready, out_valid, out_addr, out_mask, out_wdata, out_funct3, out_is_store,
               out_misalign, out_illegal, out_idx, busy, count
    );

    modport master (
        output flush, in_valid, rs1_v, rs2_v, imm, funct3, is_store, idx_in, out_ready,
        input  in_ready, out_valid, out_addr, out_mask, out_wdata, out_funct3, out_is_store,
               out_misalign, out_illegal, out_idx, busy, count
    );
endinterface

// File: rtl/mem_agu_fifo.sv
// rtl/mem_agu_fifo.sv - DEPTH-entry valid/ready FIFO with flush, pop-side ready feeds push-side ready
module mem_agu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_data_o,
    output logic [CNT_W-1:0] count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Pointers wrap at DEPTH so non power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid_o = (count_q != '0);
    assign in_ready_o  = (count_q < CNT_W'(DEPTH)) || (out_valid_o && out_ready_i);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // Next pointer/occupancy; flush discards everything including this cycle's push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, cleared on reset so the head data reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end
endmodule

// File: rtl/fu_mem_agu.sv
// rtl/fu_mem_agu.sv - registered address-generation unit feeding the load/store queue
module fu_mem_agu
    import fu_mem_agu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    fu_mem_agu_if.slave bus
);
    localparam int MASK_W = XLEN / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [MASK_W-1:0] mask;
        logic [XLEN-1:0]   wdata;
        logic [2:0]        funct3;
        logic              is_store;
        logic              misalign;
        logic              illegal;
        logic [IDX_W-1:0]  idx;
    } agu_entry_t;

    logic [XLEN-1:0]   addr;
    logic [OFF_W-1:0]  off;
    mem_size_t         size;
    logic [3:0]        nbytes;
    logic              legal;
    logic              misalign;
    logic [MASK_W-1:0] ones;
    agu_entry_t        ent_in, ent_out;

    // Front end: address, lane offset, legality, byte mask and lane-shifted store data
    always_comb begin
        addr     = bus.rs1_v + bus.imm;
        off      = addr[OFF_W-1:0];
        size     = mem_size_t'(bus.funct3[1:0]);
        nbytes   = size_bytes(size);
        legal    = f3_legal(bus.funct3, bus.is_store, XLEN == 64);
        misalign = |({{(4-OFF_W){1'b0}}, off} & (nbytes - 4'd1));
        ones     = '0;
        for (int i = 0; i < MASK_W; i++) ones[i] = (4'(i) < nbytes);
        ent_in          = '0;
        ent_in.addr     = addr;
        ent_in.mask     = (misalign || !legal) ? '0 : (ones << off);
        ent_in.wdata    = (bus.is_store && legal) ? (bus.rs2_v << {off, 3'b000}) : '0;
        ent_in.funct3   = bus.funct3;
        ent_in.is_store = bus.is_store;
        ent_in.misalign = misalign;
        ent_in.illegal  = !legal;
        ent_in.idx      = bus.idx_in;
    end

    mem_agu_fifo #(
        .W     ($bits(agu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (bus.flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (ent_in),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (ent_out),
        .count_o     (bus.count)
    );

    assign bus.out_addr     = ent_out.addr;
    assign bus.out_mask     = ent_out.mask;
    assign bus.out_wdata    = ent_out.wdata;
    assign bus.out_funct3   = ent_out.funct3;
    assign bus.out_is_store = ent_out.is_store;
    assign bus.out_misalign = ent_out.misalign;
    assign bus.out_illegal  = ent_out.illegal;
    assign bus.out_idx      = ent_out.idx;
    assign bus.busy         = ~bus.in_ready;
endmodule
